// File: rtl/instr_rom_loader_pkg.sv
// Shared constants, FSM encoding and address/byte-lane helpers for the instruction ROM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_rom_loader_pkg;

  // addi x0,x0,0 -- returned whenever the array must not be observed
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Replace one little-endian byte lane of a 32-bit word
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[8*lane +: 8] = b;
    return r;
  endfunction

  // Byte fetch address to full word index; callers range-check the upper bits
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/instr_rom_loader_if.sv
// Byte-serial programming port bundle (source drives data, loader drives ready).
// Latency: n/a (wires only).
// Backpressure: a byte transfers only on a cycle where prog_valid and prog_ready are both high.
interface instr_rom_loader_if;
  logic       prog_start;
  logic       prog_valid;
  logic [7:0] prog_byte;
  logic       prog_last;
  logic       prog_ready;

  modport master (output prog_start, prog_valid, prog_byte, prog_last, input prog_ready);
  modport slave  (input prog_start, prog_valid, prog_byte, prog_last, output prog_ready);
endinterface

// File: rtl/instr_rom_loader_word_array.sv
// DEPTH_WORDS x 32 instruction storage: one synchronous write port, one asynchronous read port.
// Latency: write visible the cycle after we; read is combinational.
// Backpressure: none; contents are deliberately not reset.
module rom_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Commit a word on the write strobe; no reset so boot image survives a core reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_rom_loader.sv
// Instruction memory with combinational fetch port and byte-serial boot loader.
// Latency: fetch 0 cycles; each word commits one WRITE cycle after its 4th (or last) byte.
// Backpressure: prog_ready low in IDLE, WRITE and DONE; a full word stream costs 5 cycles/word.
module instr_rom_loader
  import instr_rom_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10,
  parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr_in,
  output logic [31:0]         instr_out,
  instr_rom_loader_if.slave   prog,
  output logic                loading,
  output logic                prog_done,
  output logic [AW:0]         words_loaded
);

  localparam logic [AW-1:0] WPTR_LAST = AW'(DEPTH_WORDS - 1);
  localparam logic [AW:0]   WL_MAX    = (AW+1)'(DEPTH_WORDS);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] wptr;
  logic [31:0]   shreg;
  logic          last_seen;
  logic [AW:0]   wl_q;
  logic          ready_c, loading_c, done_c, mem_we;
  logic          byte_acc;
  logic [31:0]   widx;
  logic          in_range;
  logic [31:0]   rd_data;

  assign byte_acc = (state == ST_LOAD) && prog.prog_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status decode
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    loading_c = 1'b0;
    done_c    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (prog.prog_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ready_c   = 1'b1;
        loading_c = 1'b1;
        if (byte_acc && (byte_cnt == 2'd3 || prog.prog_last)) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        loading_c = 1'b1;
        mem_we    = 1'b1;
        state_nxt = (last_seen || wptr == WPTR_LAST) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        loading_c = 1'b1;
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte assembly, write pointer and session word count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= 2'd0;
      wptr      <= '0;
      shreg     <= 32'd0;
      last_seen <= 1'b0;
      wl_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (prog.prog_start) begin
            byte_cnt  <= 2'd0;
            wptr      <= '0;
            shreg     <= 32'd0;
            last_seen <= 1'b0;
            wl_q      <= '0;
          end
        end
        ST_LOAD: begin
          if (byte_acc) begin
            shreg     <= lane_insert(shreg, byte_cnt, prog.prog_byte);
            byte_cnt  <= byte_cnt + 2'd1;
            last_seen <= prog.prog_last;
          end
        end
        ST_WRITE: begin
          // shreg clears here so a short final word is zero-filled
          wptr     <= wptr + 1'b1;
          byte_cnt <= 2'd0;
          shreg    <= 32'd0;
          if (wl_q != WL_MAX) wl_q <= wl_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  rom_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (shreg),
    .raddr (widx[AW-1:0]),
    .rdata (rd_data)
  );

  assign widx     = word_index(addr_in);
  assign in_range = (widx >> AW) == 32'd0;

  // The core never sees half-loaded memory: NOP during reset, loading, or outside the array
  assign instr_out = (!reset || loading_c || !in_range) ? NOP_INSTR : rd_data;

  assign prog.prog_ready = ready_c;
  assign loading         = loading_c;
  assign prog_done       = done_c;
  assign words_loaded    = wl_q;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Self-checking bench for instr_rom_loader against a byte-queue memory model.
// Latency: n/a.
// Backpressure: source waits on prog_ready with a bounded cycle budget.
module tb_instr_rom_loader;
  import instr_rom_loader_pkg::*;

  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr_in = 32'd0;
  wire  [31:0] instr_out;
  wire         loading;
  wire         prog_done;
  wire  [AW:0] words_loaded;

  instr_rom_loader_if pif();

  instr_rom_loader #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_in      (addr_in),
    .instr_out    (instr_out),
    .prog         (pif),
    .loading      (loading),
    .prog_done    (prog_done),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: memory image, which words are known, and the session in progress
  logic [31:0] model_mem [DEPTH];
  bit          mvalid    [DEPTH];
  int          mptr   = 0;
  int          mcount = 0;
  logic [7:0]  pend [$];
  logic [7:0]  img  [$];

  int          done_cnt  = 0;
  int          stall_cnt = 0;
  bit          rand_addr = 1'b0;
  logic [31:0] dir_addr  = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [7:0] b, input bit last);
    logic [31:0] w;
    if (mptr >= DEPTH) chk("accept_after_full", 32'd1, 32'd0);
    pend.push_back(b);
    if (pend.size() == 4 || last) begin
      w = 32'd0;
      for (int i = 0; i < pend.size(); i++) w = w | (32'(pend[i]) << (8 * i));
      if (mptr < DEPTH) begin
        model_mem[mptr] = w;
        mvalid[mptr]    = 1'b1;
        mptr++;
        mcount++;
      end
      pend.delete();
    end
  endtask

  // Single writer of addr_in: random fetch addresses or a directed one
  initial begin
    forever begin
      int r;
      @(posedge clk);
      #1;
      if (rand_addr) begin
        r = $urandom_range(0, 7);
        if (r == 0)      addr_in = 32'(4 * DEPTH) + $urandom_range(0, 3);
        else if (r == 1) addr_in = $urandom;
        else             addr_in = $urandom_range(0, 4 * DEPTH - 1);
      end else begin
        addr_in = dir_addr;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_instr", instr_out, NOP);
      chk("rst_loading", 32'(loading), 32'd0);
      chk("rst_ready", 32'(pif.prog_ready), 32'd0);
      chk("rst_done", 32'(prog_done), 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
    end else begin
      if (loading) begin
        chk("busy_nop", instr_out, NOP);
        if (!pif.prog_ready) stall_cnt++;
      end else begin
        chk("idle_ready", 32'(pif.prog_ready), 32'd0);
        chk("words_loaded", 32'(words_loaded), 32'(mcount));
        if (addr_in >= 32'(4 * DEPTH)) chk("oor_nop", instr_out, NOP);
        else if (mvalid[addr_in / 4]) chk("read", instr_out, model_mem[addr_in / 4]);
      end
      if (prog_done) done_cnt++;
    end
  end

  task automatic read_at(input logic [31:0] a, input logic [31:0] exp, input string name);
    rand_addr = 1'b0;
    dir_addr  = a;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk(name, instr_out, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    pif.prog_start = 1'b1;
    @(posedge clk);
    #1;
    pif.prog_start = 1'b0;
    mptr   = 0;
    mcount = 0;
    pend.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int max_wait, output bit acc);
    acc = 1'b0;
    pif.prog_valid = 1'b1;
    pif.prog_byte  = b;
    pif.prog_last  = last;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      if (pif.prog_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    pif.prog_valid = 1'b0;
    pif.prog_last  = 1'b0;
    pif.prog_byte  = $urandom_range(0, 255);
    if (acc) model_accept(b, last);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!loading) ok = 1'b1;
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // One load session from img; expects one done pulse and a ready-low cycle per word plus DONE
  task automatic run_session(input bit with_last, input int gap_max, input bit poke, input bit extra);
    int s0, d0, n, words;
    bit acc;
    n     = img.size();
    words = (n + 3) / 4;
    s0    = stall_cnt;
    d0    = done_cnt;
    start_session();
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int k = 0; k < g; k++) begin
        if (poke && k == 0 && i > 0) pif.prog_start = 1'b1;
        @(posedge clk);
        #1;
        pif.prog_start = 1'b0;
      end
      send_byte(img[i], with_last && (i == n - 1), 8, acc);
      chk("byte_accept", 32'(acc), 32'd1);
    end
    if (extra) begin
      send_byte(8'hEE, 1'b0, 12, acc);
      chk("extra_rejected", 32'(acc), 32'd0);
    end
    wait_idle();
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("stall_cycles", 32'(stall_cnt - s0), 32'(words + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, prev1;
    int s0, d0;
    bit acc;

    pif.prog_start = 1'b0;
    pif.prog_valid = 1'b0;
    pif.prog_byte  = 8'd0;
    pif.prog_last  = 1'b0;
    for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;

    // Reset held low: NOP out, everything idle
    repeat (3) @(negedge clk);
    chk("lit_rst_nop", instr_out, 32'h0000_0013);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(pif.prog_ready), 32'd0);
    chk("post_rst_loading", 32'(loading), 32'd0);
    @(posedge clk);
    #1;

    // Two-word directed load
    img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_session(1'b1, 0, 1'b0, 1'b0);
    chk("model_w0", model_mem[0], 32'h0010_0513);
    read_at(32'd0, 32'h0010_0513, "lit_two_w0");
    read_at(32'd4, 32'h0020_0593, "lit_two_w1");
    read_at(32'd7, 32'h0020_0593, "lit_lowbits_ignored");
    chk("lit_two_words", 32'(words_loaded), 32'd2);

    // Partial word zero-fill
    img = '{8'hAA, 8'hBB};
    run_session(1'b1, 0, 1'b0, 1'b0);
    read_at(32'd0, 32'h0000_BBAA, "lit_partial");
    chk("lit_partial_words", 32'(words_loaded), 32'd1);
    read_at(32'd4, 32'h0020_0593, "lit_partial_keeps_w1");

    // Stalled source with stray prog_start, random images
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 14);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
      rand_addr = 1'b1;
      run_session(1'b1, 3, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
    end

    // Fill the whole memory without prog_last, then offer one more byte
    img.delete();
    for (int i = 0; i < 4 * DEPTH; i++) img.push_back(8'($urandom_range(0, 255)));
    w0 = {img[3], img[2], img[1], img[0]};
    rand_addr = 1'b1;
    run_session(1'b0, 0, 1'b0, 1'b1);
    chk("lit_full_words", 32'(words_loaded), 32'(DEPTH));
    read_at(32'd0, w0, "full_mem0_unchanged");
    read_at(32'(4 * DEPTH), 32'h0000_0013, "lit_boundary_nop");
    read_at(32'(4 * DEPTH - 4), {img[4*DEPTH-1], img[4*DEPTH-2], img[4*DEPTH-3], img[4*DEPTH-4]},
            "full_last_word");

    // Reset after 6 bytes: word 0 kept, word 1 untouched, no done pulse
    prev1 = model_mem[1];
    s0 = stall_cnt;
    d0 = done_cnt;
    start_session();
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), 1'b0, 8, acc);
      chk("rst_mid_accept", 32'(acc), 32'd1);
    end
    reset = 1'b0;
    pend.delete();
    mcount = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_loading", 32'(loading), 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid_stalls", 32'(stall_cnt - s0), 32'd1);
    read_at(32'd0, 32'h0403_0201, "lit_rst_mid_w0");
    read_at(32'd4, prev1, "rst_mid_w1_untouched");
    chk("rst_mid_words", 32'(words_loaded), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_rom_loader.md
Name: instr_rom_loader

Overview:
- Responder side of the core's instruction-fetch interface: the core drives a byte fetch address, and this block returns the 32-bit instruction combinationally in the same cycle.
- A byte-serial programming port fills the instruction memory at boot, for example from a UART bridge.
- Sits beside the core at the top level: the core's fetch address output feeds addr_in, and instr_out feeds the core's instruction input.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words; must be a power of two.
AW, 10, word-index width; equals log2(DEPTH_WORDS).
NOP_INSTR, 32'h0000_0013, value returned when out of range or while loading (addi x0,x0,0).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
addr_in  input  32  byte fetch address from the core.
instr_out  output  32  instruction at addr_in; combinational read.
prog_start  input  1  one-cycle pulse that starts a load session.
prog_valid  input  1  prog_byte is valid this cycle.
prog_byte  input  8  programming data byte, little-endian within each word.
prog_last  input  1  qualifies the final byte of the image; sampled with prog_valid.
prog_ready  output  1  block can accept a byte this cycle.
loading  output  1  load session in progress; the top level holds the core in reset while this is high.
prog_done  output  1  one-cycle pulse when a session completes.
words_loaded  output  AW+1  number of words committed in the last or current session.

Behaviour:
- Reset (reset low): FSM goes to IDLE. Byte counter, word pointer, shift register and words_loaded clear to 0. prog_ready=0, loading=0, prog_done=0.
  - instr_out is forced to NOP_INSTR while reset is low.
  - Memory array contents are NOT cleared.
- Read path:
  - Word index is addr_in[AW+1:2]; addr_in[1:0] is ignored.
  - If addr_in[31:AW+2] is nonzero, instr_out=NOP_INSTR.
  - Zero-cycle latency, no handshake.
  - instr_out=NOP_INSTR whenever loading=1.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - prog_ready=0.
  - prog_start -> LOAD; clear wptr, byte_cnt and words_loaded.
  - prog_valid is ignored.
- LOAD:
  - prog_ready=1, loading=1.
  - A byte is accepted on prog_valid&prog_ready: shreg[8*byte_cnt +: 8] <= prog_byte; byte_cnt++.
  - Acceptance of byte_cnt==3, or of any byte with prog_last=1 -> WRITE.
  - On a prog_last-triggered exit, bytes not yet received are zero-filled; for example, 2 bytes then last gives upper 16 bits = 0.
  - prog_start in LOAD is ignored.
- WRITE (exactly 1 cycle):
  - prog_ready=0, loading=1.
  - mem[wptr] <= shreg; wptr++; words_loaded++; byte_cnt and shreg clear.
  - Go to DONE if the last byte carried prog_last, or if wptr==DEPTH_WORDS-1 (memory full). Otherwise go back to LOAD.
- DONE (1 cycle):
  - prog_done=1, loading=1, prog_ready=0.
  - Next state is IDLE; the following cycle has loading=0.
- Full memory:
  - Extra bytes after the full-memory exit are never accepted, since prog_ready=0 in IDLE.
  - Writes never wrap to word 0.
- Throughput: a sustained stream of 4 bytes costs 5 cycles per word because of the WRITE bubble.
- prog_last with no bytes pending cannot occur, because last always qualifies an accepted byte.
- Reset mid-session:
  - Immediate return to IDLE; no prog_done pulse.
  - Words already committed remain in memory; the partial word is discarded.
  - words_loaded clears.
- words_loaded saturates at DEPTH_WORDS and holds its value in IDLE until the next prog_start.

Decomposition:
- Shared package: NOP_INSTR constant, FSM state encoding (2 bits), and the byte-lane and word-index slice helpers shared with fetch logic.
- One natural sub-module, rom_word_array: DEPTH_WORDS×32 storage with one synchronous write port and one asynchronous read port. The FSM and read muxing stay in the parent.

Test Plan:
- Reset then read: hold reset low, addr_in=0 -> instr_out=32'h00000013. Release reset -> instr_out shows the preloaded mem[0]; prog_ready=0, loading=0.
- Two-word load:
  - Stimulus: prog_start, then bytes 13,05,10,00 then 93,05,20,00 with prog_last on the final byte.
  - Required: mem[0]=32'h00100513, mem[1]=32'h00200593, prog_done pulses once, words_loaded=2.
  - After loading=0, addr_in=4 -> 32'h00200593.
- Partial word: prog_start, bytes AA,BB with prog_last on BB -> mem[0]=32'h0000BBAA, words_loaded=1.
- Stalled source: insert idle cycles between bytes and assert prog_start mid-LOAD -> identical memory image. prog_ready is low exactly in WRITE and DONE cycles. The session does not restart.
- Boundaries:
  - addr_in=4*(DEPTH_WORDS) -> NOP.
  - Load DEPTH_WORDS+1 words without last -> DONE after word DEPTH_WORDS-1; extra byte not accepted; mem[0] unchanged.
- Reset mid-load: reset low after 6 bytes -> FSM IDLE, no prog_done, mem[0] holds word 0, mem[1] is not written.
